// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and button-priority decode for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_CLEAR = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_START = 3'd3,
        CMD_LAP   = 3'd4
    } btn_cmd_e;

    localparam int unsigned DIGIT_MAX        = 9;
    localparam int unsigned TENS_MAX         = 5;
    localparam int unsigned DEF_TICKS_PER_CS = 10;
    localparam int unsigned DEF_MAX_MIN_TENS = 5;
    localparam int unsigned PRESC_W          = 4;

    typedef struct packed {
        logic [2:0] min_tens;
        logic [3:0] min_ones;
        logic [2:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] cs_tens;
        logic [3:0] cs_ones;
    } sw_time_t;

    // Highest-priority button that has an effect in the current state wins.
    function automatic btn_cmd_e decode_cmd(input state_e st, input logic clr, input logic stp,
                                            input logic strt, input logic lap);
        btn_cmd_e c;
        c = CMD_NONE;
        if (clr)                         c = CMD_CLEAR;
        else if (stp && st == RUNNING)   c = CMD_STOP;
        else if (strt && st != RUNNING)  c = CMD_START;
        else if (lap && st == RUNNING)   c = CMD_LAP;
        return c;
    endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Button/tick inputs and display/status outputs of the stopwatch controller.
interface stopwatch_controller_if;
    logic       start_btn;
    logic       stop_btn;
    logic       clear_btn;
    logic       lap_btn;
    logic       ms_tick;
    logic       timer_enable;
    logic       running;
    logic       paused;
    logic       lap_active;
    logic       rollover;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;

    modport master (
        output start_btn, stop_btn, clear_btn, lap_btn, ms_tick,
        input  timer_enable, running, paused, lap_active, rollover,
        input  min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones
    );

    modport slave (
        input  start_btn, stop_btn, clear_btn, lap_btn, ms_tick,
        output timer_enable, running, paused, lap_active, rollover,
        output min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time chain: wraps at MAX and carries combinationally.
module bcd_digit_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_in_i,
    input  logic         clr_i,
    output logic [W-1:0] value_o,
    output logic [W-1:0] value_d_c,
    output logic         carry_out_c
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign carry_out_c = inc_in_i && (value_q == MAX_V);

    always_comb begin
        value_d = value_q;
        if (clr_i)         value_d = '0;
        else if (inc_in_i) value_d = (value_q == MAX_V) ? '0 : value_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value_o   = value_q;
    assign value_d_c = value_d;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch run-state FSM, ms-tick prescaler, BCD MM:SS.cc chain and lap-freeze display.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICKS_PER_CS = DEF_TICKS_PER_CS,
    parameter int unsigned MAX_MIN_TENS = DEF_MAX_MIN_TENS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stopwatch_controller_if.slave  bus
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CS - 1);

    state_e             state_q, state_d;
    btn_cmd_e           cmd;
    logic               tick_ok, cs_inc, clr_cnt;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               lap_active_q, lap_active_d;
    sw_time_t           live_q, live_d, snap_q, snap_d, disp_q, disp_d;
    logic               timer_enable_q, running_q, paused_q, rollover_q;

    logic [3:0] cs1_q, cs1_d, cs10_q, cs10_d, s1_q, s1_d, m1_q, m1_d;
    logic [2:0] s10_q, s10_d, m10_q, m10_d;
    logic       cs1_co, cs10_co, s1_co, s10_co, m1_co, m10_co;

    assign cmd = decode_cmd(state_q, bus.clear_btn, bus.stop_btn, bus.start_btn, bus.lap_btn);

    // Next state, lap toggle/snapshot and prescaler.
    always_comb begin
        state_d      = state_q;
        lap_active_d = lap_active_q;
        snap_d       = snap_q;
        presc_d      = presc_q;
        clr_cnt      = 1'b0;
        unique case (cmd)
            CMD_CLEAR: begin
                state_d      = IDLE;
                lap_active_d = 1'b0;
                clr_cnt      = 1'b1;
            end
            CMD_STOP:  state_d = PAUSED;
            CMD_START: state_d = RUNNING;
            CMD_LAP: begin
                lap_active_d = !lap_active_q;
                if (!lap_active_q) snap_d = live_q;
            end
            default: ;
        endcase
        tick_ok = bus.ms_tick && (state_q == RUNNING) && (cmd != CMD_STOP) && (cmd != CMD_CLEAR);
        cs_inc  = tick_ok && (presc_q == PRESC_LAST);
        if (clr_cnt)      presc_d = '0;
        else if (cs_inc)  presc_d = '0;
        else if (tick_ok) presc_d = presc_q + PRESC_W'(1);
    end

    bcd_digit_counter #(.W(4), .MAX(DIGIT_MAX)) u_cs1 (
        .clk(clk), .rst_n(rst_n), .inc_in_i(cs_inc), .clr_i(clr_cnt),
        .value_o(cs1_q), .value_d_c(cs1_d), .carry_out_c(cs1_co));
    bcd_digit_counter #(.W(4), .MAX(DIGIT_MAX)) u_cs10 (
        .clk(clk), .rst_n(rst_n), .inc_in_i(cs1_co), .clr_i(clr_cnt),
        .value_o(cs10_q), .value_d_c(cs10_d), .carry_out_c(cs10_co));
    bcd_digit_counter #(.W(4), .MAX(DIGIT_MAX)) u_s1 (
        .clk(clk), .rst_n(rst_n), .inc_in_i(cs10_co), .clr_i(clr_cnt),
        .value_o(s1_q), .value_d_c(s1_d), .carry_out_c(s1_co));
    bcd_digit_counter #(.W(3), .MAX(TENS_MAX)) u_s10 (
        .clk(clk), .rst_n(rst_n), .inc_in_i(s1_co), .clr_i(clr_cnt),
        .value_o(s10_q), .value_d_c(s10_d), .carry_out_c(s10_co));
    bcd_digit_counter #(.W(4), .MAX(DIGIT_MAX)) u_m1 (
        .clk(clk), .rst_n(rst_n), .inc_in_i(s10_co), .clr_i(clr_cnt),
        .value_o(m1_q), .value_d_c(m1_d), .carry_out_c(m1_co));
    bcd_digit_counter #(.W(3), .MAX(MAX_MIN_TENS)) u_m10 (
        .clk(clk), .rst_n(rst_n), .inc_in_i(m1_co), .clr_i(clr_cnt),
        .value_o(m10_q), .value_d_c(m10_d), .carry_out_c(m10_co));

    assign live_q = {m10_q, m1_q, s10_q, s1_q, cs10_q, cs1_q};
    assign live_d = {m10_d, m1_d, s10_d, s1_d, cs10_d, cs1_d};
    assign disp_d = lap_active_d ? snap_d : live_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            lap_active_q   <= 1'b0;
            snap_q         <= '0;
            disp_q         <= '0;
            timer_enable_q <= 1'b0;
            running_q      <= 1'b0;
            paused_q       <= 1'b0;
            rollover_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            lap_active_q   <= lap_active_d;
            snap_q         <= snap_d;
            disp_q         <= disp_d;
            timer_enable_q <= (state_d == RUNNING);
            running_q      <= (state_d == RUNNING);
            paused_q       <= (state_d == PAUSED);
            rollover_q     <= m10_co;
        end
    end

    assign bus.timer_enable = timer_enable_q;
    assign bus.running      = running_q;
    assign bus.paused       = paused_q;
    assign bus.lap_active   = lap_active_q;
    assign bus.rollover     = rollover_q;
    assign bus.min_tens     = disp_q.min_tens;
    assign bus.min_ones     = disp_q.min_ones;
    assign bus.sec_tens     = disp_q.sec_tens;
    assign bus.sec_ones     = disp_q.sec_ones;
    assign bus.cs_tens      = disp_q.cs_tens;
    assign bus.cs_ones      = disp_q.cs_ones;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench: default instance for run/pause/lap, fast instance (1 tick/cs, 9:59.99 wrap) for carries and rollover.
module tb_stopwatch_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    stopwatch_controller_if sw();
    stopwatch_controller_if fw();

    stopwatch_controller u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw)
    );

    stopwatch_controller #(.TICKS_PER_CS(1), .MAX_MIN_TENS(0)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fw)
    );

    always #10 clk = ~clk;

    function automatic logic [21:0] bcd(input int mt, input int mo, input int st,
                                        input int so, input int ct, input int co);
        return {3'(mt), 4'(mo), 3'(st), 4'(so), 4'(ct), 4'(co)};
    endfunction

    function automatic logic [21:0] main_time();
        return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones, sw.cs_tens, sw.cs_ones};
    endfunction

    function automatic logic [21:0] fast_time();
        return {fw.min_tens, fw.min_ones, fw.sec_tens, fw.sec_ones, fw.cs_tens, fw.cs_ones};
    endfunction

    // {timer_enable, running, paused, lap_active, rollover}
    function automatic logic [4:0] main_flags();
        return {sw.timer_enable, sw.running, sw.paused, sw.lap_active, sw.rollover};
    endfunction

    function automatic logic [4:0] fast_flags();
        return {fw.timer_enable, fw.running, fw.paused, fw.lap_active, fw.rollover};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sw.ms_tick = 1'b1;
            cyc();
        end
        sw.ms_tick = 1'b0;
    endtask

    task automatic fticks(input int n);
        fw.ms_tick = 1'b1;
        repeat (n) cyc();
        fw.ms_tick = 1'b0;
    endtask

    task automatic press(input logic strt, input logic stp, input logic clr,
                         input logic lap, input logic tick);
        sw.start_btn = strt;
        sw.stop_btn  = stp;
        sw.clear_btn = clr;
        sw.lap_btn   = lap;
        sw.ms_tick   = tick;
        cyc();
        sw.start_btn = 1'b0;
        sw.stop_btn  = 1'b0;
        sw.clear_btn = 1'b0;
        sw.lap_btn   = 1'b0;
        sw.ms_tick   = 1'b0;
    endtask

    initial begin
        sw.start_btn = 1'b0; sw.stop_btn = 1'b0; sw.clear_btn = 1'b0;
        sw.lap_btn   = 1'b0; sw.ms_tick  = 1'b0;
        fw.start_btn = 1'b0; fw.stop_btn = 1'b0; fw.clear_btn = 1'b0;
        fw.lap_btn   = 1'b0; fw.ms_tick  = 1'b0;

        repeat (3) cyc();
        chk("reset_flags", 32'(main_flags()), 32'(5'b00000));
        chk("reset_time", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        cyc();

        // start, then 25 ticks: 2 cs with prescaler at 5
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_flags", 32'(main_flags()), 32'(5'b11000));
        ticks(25);
        chk("t_25", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 2)));
        ticks(4);
        chk("t_29", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 2)));
        ticks(1);
        chk("t_30", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 3)));
        ticks(60);
        chk("t_09", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 9)));
        ticks(10);
        chk("cs_carry", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 1, 0)));

        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_in_run", 32'(main_flags()), 32'(5'b11000));

        // stop with coincident tick: tick must be discarded
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("stop_tick_flags", 32'(main_flags()), 32'(5'b00100));
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stop_in_pause", 32'(main_flags()), 32'(5'b00100));
        ticks(50);
        chk("paused_hold", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 1, 0)));
        chk("te_low_paused", 32'(main_flags()), 32'(5'b00100));
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_flags", 32'(main_flags()), 32'(5'b11000));
        ticks(9);
        chk("tick_discarded", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 1, 0)));
        ticks(1);
        chk("resume_count", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 1, 1)));

        // lap freeze at 00:05.00
        ticks(4890);
        chk("at_5s", 32'(main_time()), 32'(bcd(0, 0, 0, 5, 0, 0)));
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_flags", 32'(main_flags()), 32'(5'b11010));
        ticks(300);
        chk("lap_frozen", 32'(main_time()), 32'(bcd(0, 0, 0, 5, 0, 0)));
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_release", 32'(main_time()), 32'(bcd(0, 0, 0, 5, 3, 0)));
        chk("lap_release_flags", 32'(main_flags()), 32'(5'b11000));

        press(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("stop_beats_lap", 32'(main_flags()), 32'(5'b00100));

        // lap_active survives stop/start
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lap_persist_pause", 32'(main_flags()), 32'(5'b00110));
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(10);
        chk("lap_persist_flags", 32'(main_flags()), 32'(5'b11010));
        chk("lap_persist_time", 32'(main_time()), 32'(bcd(0, 0, 0, 5, 3, 0)));

        // clear dominates everything
        press(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clear_all_flags", 32'(main_flags()), 32'(5'b00000));
        chk("clear_all_time", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 0)));
        press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_clear_idle", 32'(main_flags()), 32'(5'b00000));
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_idle", 32'(main_flags()), 32'(5'b00000));

        // fast instance: minute carry and 09:59.99 wrap
        fw.start_btn = 1'b1;
        cyc();
        fw.start_btn = 1'b0;
        chk("f_start", 32'(fast_flags()), 32'(5'b11000));
        fticks(5999);
        chk("f_59_99", 32'(fast_time()), 32'(bcd(0, 0, 5, 9, 9, 9)));
        fticks(1);
        chk("f_min_carry", 32'(fast_time()), 32'(bcd(0, 1, 0, 0, 0, 0)));
        fticks(53999);
        chk("f_pre_wrap", 32'(fast_time()), 32'(bcd(0, 9, 5, 9, 9, 9)));
        chk("f_pre_wrap_flags", 32'(fast_flags()), 32'(5'b11000));
        fticks(1);
        chk("f_wrap_time", 32'(fast_time()), 32'(bcd(0, 0, 0, 0, 0, 0)));
        chk("f_wrap_flags", 32'(fast_flags()), 32'(5'b11001));
        cyc();
        chk("f_roll_1cyc", 32'(fast_flags()), 32'(5'b11000));
        fticks(1);
        chk("f_continue", 32'(fast_time()), 32'(bcd(0, 0, 0, 0, 0, 1)));

        // asynchronous reset mid-run
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(15);
        chk("pre_reset", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 1)));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_flags", 32'(main_flags()), 32'(5'b00000));
        chk("async_reset_time", 32'(main_time()), 32'(bcd(0, 0, 0, 0, 0, 0)));
        chk("async_reset_fast", 32'(fast_time()), 32'(bcd(0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequences the 1 ms timer block for the stopwatch design.
- Decodes start/stop/clear/lap button pulses into a run state, drives the timer's enable, and accumulates its 1 ms ticks into a BCD MM:SS.cc time.
- Provides a lap-freeze display path.
- Sits between the debounced button conditioners and the seven-segment display driver.

Parameters:
- TICKS_PER_CS, 10, ms ticks per centisecond increment (legal range 1..15).
- MAX_MIN_TENS, 5, highest minute-tens digit before rollover.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- start_btn  in  1  single-cycle pulse, debounced upstream
- stop_btn  in  1  single-cycle pulse
- clear_btn  in  1  single-cycle pulse
- lap_btn  in  1  single-cycle pulse
- ms_tick  in  1  one-cycle pulse from the 1 ms timer
- timer_enable  out  1  drives the 1 ms timer's enable
- running  out  1  state == RUNNING
- paused  out  1  state == PAUSED
- lap_active  out  1  display is frozen on a lap snapshot
- min_tens  out  3  displayed minute tens, BCD
- min_ones  out  4  displayed minute ones
- sec_tens  out  3  displayed second tens
- sec_ones  out  4  displayed second ones
- cs_tens  out  4  displayed centisecond tens
- cs_ones  out  4  displayed centisecond ones
- rollover  out  1  one-cycle pulse when the time wraps 59:59.99 -> 00:00.00

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All live counters, snapshot registers and digit outputs = 0.
  - timer_enable, running, paused, lap_active, rollover = 0.
- States: IDLE, RUNNING, PAUSED. All outputs are registered.
- Button priority in one cycle: clear > stop > start > lap. Only the highest-priority applicable button acts; the others are ignored that cycle.
- State transitions:
  - IDLE --start--> RUNNING.
  - RUNNING --stop--> PAUSED.
  - PAUSED --start--> RUNNING, resuming from the held time.
  - any state --clear--> IDLE: counters zeroed, lap_active cleared.
  - stop in IDLE or PAUSED: no effect. start in RUNNING: no effect.
- timer_enable is 1 exactly when state == RUNNING, registered, so it rises the cycle after start is sampled.
  - Dropping timer_enable restarts the timer's internal count. Sub-millisecond elapsed time is discarded on each pause; this is accepted.
- ms_tick handling:
  - Counted only when state == RUNNING. Ignored in IDLE and PAUSED.
  - A tick coincident with an accepted stop or clear is discarded.
- Time chain:
  - A 4-bit prescaler counts ms ticks 0..TICKS_PER_CS-1. On its terminal tick it returns to 0 and increments centiseconds.
  - BCD cascade: cs_ones 0-9, cs_tens 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0..MAX_MIN_TENS.
  - Each digit carries into the next in the same cycle; the whole chain updates in 1 cycle.
  - Digit outputs reflect a tick on the cycle after it is sampled.
- Wrap: incrementing from 59:59.99 gives 00:00.00 and the prescaler resets. rollover pulses high for 1 cycle coincident with the zeroed digits. Counting continues in RUNNING.
- Lap function:
  - lap in RUNNING with lap_active=0: copy the live time into the snapshot registers, set lap_active=1. Digit outputs show the snapshot while the live counters keep running.
  - lap in RUNNING with lap_active=1: clear lap_active; outputs return to the live time next cycle.
  - lap in IDLE or PAUSED: no effect.
  - lap_active persists across stop/start; only lap or clear clears it.
- Reset asserted mid-count: immediate return to the reset values, regardless of state.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state enum: IDLE, RUNNING, PAUSED.
  - BCD digit limit constants: 9, 5.
  - button priority encoding.
  - default TICKS_PER_CS.
- One sub-module, bcd_digit_counter: a single digit with parameterised max, inc_in, clr, and carry_out = inc_in && value == max. Instantiated six times.
- Button decode, FSM, prescaler, snapshot and output mux stay in the top level.

Test Plan:
- Reset then start, 25 ms ticks -> timer_enable = 1 one cycle after start; digits 00:00.02, prescaler at 5; running = 1.
- Running at 00:00.09 plus 10 ticks -> 00:00.10, carry into cs_tens. Preset 00:59.99 plus 10 ticks -> 01:00.00.
- Run to 12:34.56, stop, apply 50 ticks, start, 10 ticks -> paused = 1 and time held during the pause; resumes to 12:34.57; timer_enable low while paused.
- At 00:05.00, lap, then 300 ticks -> outputs frozen at 00:05.00 with lap_active = 1. Second lap -> outputs show 00:05.30.
- Preset 59:59.99, apply 10 ticks -> 00:00.00 with rollover high exactly 1 cycle, still running.
- Simultaneous edge cases:
  - start + clear in IDLE -> stays IDLE.
  - stop + ms_tick in RUNNING -> PAUSED, tick discarded.
  - rst_n low mid-run -> all outputs 0 asynchronously.
